// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - operand forwarding, load-use / multi-cycle hazard stall and busy scoreboard
module hazard_forward_ctrl #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int MC_DEPTH = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]         id_src,
  input  logic [NUM_SRC-1:0]                id_src_used,
  input  logic [REG_AW-1:0]                 id_dst,
  input  logic                              id_wr,
  input  logic                              id_is_load,
  input  logic                              id_is_mc,
  input  logic                              flush,
  input  logic                              mc_done,
  input  logic [REG_AW-1:0]                 mc_dst,
  input  logic [NUM_SRC*REG_AW-1:0]         ex_src,
  input  logic [NUM_FWD*REG_AW-1:0]         fwd_dst,
  input  logic [NUM_FWD-1:0]                fwd_wr,
  input  logic [NUM_FWD*DATA_W-1:0]         fwd_data,
  output logic [NUM_SRC-1:0]                ex_fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]         ex_fwd_data,
  output logic                              stall_id,
  output logic [2**REG_AW-1:0]              mc_busy,
  output logic [$clog2(MC_DEPTH+1)-1:0]     mc_count
);

  localparam int NREG  = 2**REG_AW;
  localparam int CNT_W = $clog2(MC_DEPTH+1);

  logic [REG_AW-1:0] ex_dst_q;
  logic              ex_wr_q;
  logic              ex_load_q;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_n;
  logic [CNT_W-1:0]  count_q;

  logic load_use, raw_hit, waw_hit, cap_hit;
  logic dst_rel, done_eff, set_eff, stall_raw, issue;

  function automatic logic is_zero(input logic [REG_AW-1:0] r);
    return (ZERO_REG != 0) && (r == '0);
  endfunction

  assign mc_busy  = busy_q;
  assign mc_count = count_q;

  // Stages are walked oldest to youngest so the youngest match is the last write.
  always_comb begin
    ex_fwd_sel  = '0;
    ex_fwd_data = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (rst_n && !is_zero(ex_src[s*REG_AW +: REG_AW])) begin
        for (int k = NUM_FWD-1; k >= 0; k--) begin
          if (fwd_wr[k] && (fwd_dst[k*REG_AW +: REG_AW] == ex_src[s*REG_AW +: REG_AW])) begin
            ex_fwd_sel[s]                  = 1'b1;
            ex_fwd_data[s*DATA_W +: DATA_W] = fwd_data[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_comb begin
    load_use = 1'b0;
    raw_hit  = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_src_used[s] && !is_zero(id_src[s*REG_AW +: REG_AW])) begin
        if (ex_load_q && ex_wr_q && (id_src[s*REG_AW +: REG_AW] == ex_dst_q))
          load_use = 1'b1;
        if (busy_q[id_src[s*REG_AW +: REG_AW]])
          raw_hit = 1'b1;
      end
    end
  end

  assign dst_rel  = id_wr && !is_zero(id_dst);
  assign waw_hit  = dst_rel && busy_q[id_dst];
  // Only a done that actually retires an op frees a slot, so the count cannot overflow.
  assign done_eff = mc_done && busy_q[mc_dst];
  assign cap_hit  = id_is_mc && (count_q == CNT_W'(MC_DEPTH)) && !done_eff;

  assign stall_raw = id_valid && (load_use || raw_hit || waw_hit || cap_hit);
  assign stall_id  = rst_n && stall_raw;
  assign issue     = id_valid && !stall_raw && !flush;
  assign set_eff   = issue && id_is_mc && dst_rel;

  always_comb begin
    busy_n = busy_q;
    if (done_eff) busy_n[mc_dst] = 1'b0;
    if (set_eff)  busy_n[id_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_dst_q  <= '0;
      ex_wr_q   <= 1'b0;
      ex_load_q <= 1'b0;
      busy_q    <= '0;
      count_q   <= '0;
    end else begin
      if (issue) begin
        ex_dst_q  <= id_dst;
        ex_wr_q   <= id_wr;
        ex_load_q <= id_is_load;
      end else begin
        ex_wr_q   <= 1'b0;
        ex_load_q <= 1'b0;
      end
      busy_q <= busy_n;
      case ({set_eff, done_eff})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed self-checking bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [7:0]  id_src;
  logic [1:0]  id_src_used;
  logic [3:0]  id_dst;
  logic        id_wr;
  logic        id_is_load;
  logic        id_is_mc;
  logic        flush;
  logic        mc_done;
  logic [3:0]  mc_dst;
  logic [7:0]  ex_src;
  logic [7:0]  fwd_dst;
  logic [1:0]  fwd_wr;
  logic [63:0] fwd_data;
  logic [1:0]  ex_fwd_sel;
  logic [63:0] ex_fwd_data;
  logic        stall_id;
  logic [15:0] mc_busy;
  logic [1:0]  mc_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_wr(id_wr),
    .id_is_load(id_is_load), .id_is_mc(id_is_mc), .flush(flush),
    .mc_done(mc_done), .mc_dst(mc_dst), .ex_src(ex_src), .fwd_dst(fwd_dst),
    .fwd_wr(fwd_wr), .fwd_data(fwd_data), .ex_fwd_sel(ex_fwd_sel),
    .ex_fwd_data(ex_fwd_data), .stall_id(stall_id), .mc_busy(mc_busy),
    .mc_count(mc_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_src = '0; id_src_used = '0; id_dst = '0; id_wr = 0;
    id_is_load = 0; id_is_mc = 0; flush = 0; mc_done = 0; mc_dst = '0;
    ex_src = '0; fwd_dst = '0; fwd_wr = '0; fwd_data = '0;
  endtask

  task automatic issue_mc(input logic [3:0] dst);
    idle();
    id_valid = 1; id_is_mc = 1; id_wr = 1; id_dst = dst;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    fwd_wr = 2'b01; fwd_dst = 8'h05; fwd_data = 64'h1234; ex_src = 8'h05;
    tick(); tick();
    n_checks++; if (mc_busy !== 16'h0) begin n_fail++; $display("FAIL reset_busy got %h want 0000", mc_busy); end
    n_checks++; if (mc_count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", mc_count); end
    n_checks++; if (ex_fwd_sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel_forced got %b want 00", ex_fwd_sel); end
    n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_id); end
    rst_n = 1;
    idle();
    tick();
  endtask

  task automatic test_forward();
    idle();
    fwd_wr = 2'b11; fwd_dst = {4'd5, 4'd5}; fwd_data = {32'hAAAA, 32'h1111};
    ex_src = {4'd9, 4'd5};
    #1;
    n_checks++; if (ex_fwd_sel !== 2'b01) begin n_fail++; $display("FAIL fwd_sel_prio got %b want 01", ex_fwd_sel); end
    n_checks++; if (ex_fwd_data !== {32'h0, 32'h1111}) begin n_fail++; $display("FAIL fwd_data_prio got %h want %h", ex_fwd_data, {32'h0, 32'h1111}); end
    fwd_wr = 2'b10;
    ex_src = {4'd5, 4'd5};
    #1;
    n_checks++; if (ex_fwd_sel !== 2'b11) begin n_fail++; $display("FAIL fwd_sel_old got %b want 11", ex_fwd_sel); end
    n_checks++; if (ex_fwd_data !== {32'hAAAA, 32'hAAAA}) begin n_fail++; $display("FAIL fwd_data_old got %h want %h", ex_fwd_data, {32'hAAAA, 32'hAAAA}); end
    fwd_wr = 2'b11; fwd_dst = {4'd6, 4'd5}; ex_src = {4'd6, 4'd7};
    #1;
    n_checks++; if (ex_fwd_sel !== 2'b10 || ex_fwd_data !== {32'hAAAA, 32'h0}) begin n_fail++; $display("FAIL fwd_mixed got %b/%h want 10/%h", ex_fwd_sel, ex_fwd_data, {32'hAAAA, 32'h0}); end
    idle();
  endtask

  task automatic test_load_use();
    idle();
    id_valid = 1; id_wr = 1; id_dst = 4'd3; id_is_load = 1;
    #1;
    n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL lu_load_issue got %b want 0", stall_id); end
    tick();
    id_is_load = 0; id_dst = 4'd8; id_src = {4'd0, 4'd3}; id_src_used = 2'b01;
    #1;
    n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b want 1", stall_id); end
    tick();
    n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL lu_one_cycle got %b want 0", stall_id); end
    tick();
    id_is_load = 1; id_dst = 4'd3; id_src_used = 2'b00;
    tick();
    id_is_load = 0; id_dst = 4'd8; id_src = {4'd0, 4'd3}; id_src_used = 2'b00;
    #1;
    n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL lu_unused_src got %b want 0", stall_id); end
    idle();
    tick();
  endtask

  task automatic test_mc_raw();
    issue_mc(4'd7);
    n_checks++; if (mc_busy[7] !== 1'b1 || mc_count !== 2'd1) begin n_fail++; $display("FAIL raw_issue got busy7=%b cnt=%0d want 1/1", mc_busy[7], mc_count); end
    id_valid = 1; id_wr = 1; id_dst = 4'd2; id_src = {4'd0, 4'd7}; id_src_used = 2'b01;
    tick(); tick();
    n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL raw_hold got %b want 1", stall_id); end
    mc_done = 1; mc_dst = 4'd7;
    #1;
    n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL raw_no_bypass got %b want 1", stall_id); end
    tick();
    mc_done = 0;
    #1;
    n_checks++; if (stall_id !== 1'b0 || mc_busy[7] !== 1'b0 || mc_count !== 2'd0) begin n_fail++; $display("FAIL raw_release got stall=%b busy7=%b cnt=%0d want 0/0/0", stall_id, mc_busy[7], mc_count); end
    idle();
    tick();
  endtask

  task automatic test_capacity();
    issue_mc(4'd1);
    issue_mc(4'd2);
    n_checks++; if (mc_count !== 2'd2) begin n_fail++; $display("FAIL cap_count got %0d want 2", mc_count); end
    id_valid = 1; id_is_mc = 1; id_wr = 1; id_dst = 4'd5;
    #1;
    n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL cap_stall got %b want 1", stall_id); end
    mc_done = 1; mc_dst = 4'd1;
    #1;
    n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL cap_done_release got %b want 0", stall_id); end
    tick();
    idle();
    n_checks++; if (mc_count !== 2'd2 || mc_busy !== 16'h0024) begin n_fail++; $display("FAIL cap_swap got cnt=%0d busy=%h want 2/0024", mc_count, mc_busy); end
    mc_done = 1; mc_dst = 4'd9;
    tick();
    n_checks++; if (mc_count !== 2'd2) begin n_fail++; $display("FAIL cap_spurious got %0d want 2", mc_count); end
    mc_dst = 4'd2; tick();
    mc_dst = 4'd5; tick();
    idle();
    n_checks++; if (mc_count !== 2'd0 || mc_busy !== 16'h0) begin n_fail++; $display("FAIL cap_drain got cnt=%0d busy=%h want 0/0000", mc_count, mc_busy); end
  endtask

  task automatic test_zero_reg();
    idle();
    fwd_wr = 2'b01; fwd_dst = 8'h00; fwd_data = 64'h1234; ex_src = 8'h00;
    #1;
    n_checks++; if (ex_fwd_sel !== 2'b00 || ex_fwd_data !== 64'h0) begin n_fail++; $display("FAIL zero_fwd got %b/%h want 00/0", ex_fwd_sel, ex_fwd_data); end
    issue_mc(4'd0);
    n_checks++; if (mc_busy !== 16'h0 || mc_count !== 2'd0) begin n_fail++; $display("FAIL zero_mc got busy=%h cnt=%0d want 0000/0", mc_busy, mc_count); end
  endtask

  task automatic test_back_to_back();
    issue_mc(4'd4);
    id_valid = 1; id_is_mc = 1; id_wr = 1; id_dst = 4'd4;
    mc_done = 1; mc_dst = 4'd4;
    #1;
    n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL b2b_waw got %b want 1", stall_id); end
    tick();
    mc_done = 0;
    #1;
    n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL b2b_waw_drop got %b want 0", stall_id); end
    tick();
    idle();
    n_checks++; if (mc_busy[4] !== 1'b1 || mc_count !== 2'd1) begin n_fail++; $display("FAIL b2b_net got busy4=%b cnt=%0d want 1/1", mc_busy[4], mc_count); end
    issue_mc(4'd6);
    n_checks++; if (mc_count !== 2'd2) begin n_fail++; $display("FAIL b2b_two_pending got %0d want 2", mc_count); end
    id_valid = 1; id_wr = 1; id_dst = 4'd8; id_src = {4'd6, 4'd4}; id_src_used = 2'b11;
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    n_checks++; if (mc_busy !== 16'h0 || mc_count !== 2'd0 || stall_id !== 1'b0) begin n_fail++; $display("FAIL mid_reset got busy=%h cnt=%0d stall=%b want 0000/0/0", mc_busy, mc_count, stall_id); end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mc_raw();
    test_capacity();
    test_zero_reg();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
